sa_ram_80x17_rd_arb: RTL and testbench

- Controller and arbiter for one 80x17 two-port RAM macro with a registered read address (re) and a registered output (ore).
- Shares the single read port between two read clients using round-robin arbitration.
- Sequences the two-stage read pipeline with back-pressure, passes writes through, and drives the macro bypass port for write-capture collisions and out-of-range reads.
- Sits between the systolic-array buffer logic and the RAM instance.

---
 rtl/sa_ram_80x17_rd_arb_if.sv | 43 ++++
 rtl/sa_ram_80x17_rd_arb.sv | 137 +++++++++++++
 tb/tb_sa_ram_80x17_rd_arb.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_ram_80x17_rd_arb_if.sv
// rtl/sa_ram_80x17_rd_arb_if.sv - macro-side port bundle of the 80x17 read arbiter
// master: controller side; slave: RAM macro side (returns the output-register data).
interface sa_ram_80x17_rd_arb_if #(
  parameter int AW = 7,
  parameter int DW = 17
);
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic          ram_ore;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic          ram_byp_sel;
  logic [DW-1:0] ram_dbyp;
  logic [31:0]   ram_pwrbus_ram_pd;
  logic [DW-1:0] ram_dout;

  modport master (
    output ram_ra,
    output ram_re,
    output ram_ore,
    output ram_wa,
    output ram_we,
    output ram_di,
    output ram_byp_sel,
    output ram_dbyp,
    output ram_pwrbus_ram_pd,
    input  ram_dout
  );

  modport slave (
    input  ram_ra,
    input  ram_re,
    input  ram_ore,
    input  ram_wa,
    input  ram_we,
    input  ram_di,
    input  ram_byp_sel,
    input  ram_dbyp,
    input  ram_pwrbus_ram_pd,
    output ram_dout
  );
endinterface

// File: rtl/sa_ram_80x17_rd_arb.sv
// rtl/sa_ram_80x17_rd_arb.sv - round-robin read arbiter and pipeline sequencer for an 80x17 RAM
// Stage A mirrors the macro's latched read address; stage B mirrors its output register.
module sa_ram_80x17_rd_arb #(
  parameter int DEPTH = 80,
  parameter int AW    = 7,
  parameter int DW    = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req_vld,
  output logic          r0_req_rdy,
  input  logic [AW-1:0] r0_req_addr,
  input  logic          r1_req_vld,
  output logic          r1_req_rdy,
  input  logic [AW-1:0] r1_req_addr,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          wr_err,
  output logic          busy,
  sa_ram_80x17_rd_arb_if.master ram
);

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  logic          a_vld;
  logic          a_id;
  logic          a_err;
  logic [AW-1:0] a_addr;
  logic          b_vld;
  logic          b_id;
  logic          b_err;
  logic          rr_last;

  logic          adv_b;
  logic          adv_a;
  logic          issue_ok;
  logic          issue;
  logic          gnt1;
  logic [AW-1:0] gnt_addr;
  logic          wr_ok;
  logic          collide;

  always_comb begin
    adv_b    = !b_vld || rsp_rdy;
    adv_a    = adv_b;
    issue_ok = !a_vld || adv_a;

    // Tie goes to the client that was not granted last.
    gnt1 = 1'b0;
    if (r0_req_vld && r1_req_vld) begin
      gnt1 = !rr_last;
    end else begin
      gnt1 = r1_req_vld;
    end
    gnt_addr = gnt1 ? r1_req_addr : r0_req_addr;
    issue    = issue_ok && (r0_req_vld || r1_req_vld);

    r0_req_rdy = issue && !gnt1;
    r1_req_rdy = issue && gnt1;
  end

  always_comb begin
    wr_ok   = wr_addr < LIMIT;
    collide = wr_vld && wr_ok && (wr_addr == a_addr);

    ram.ram_ra            = gnt_addr;
    ram.ram_re            = issue;
    ram.ram_ore           = a_vld && adv_a;
    ram.ram_wa            = wr_addr;
    ram.ram_we            = wr_vld && wr_ok;
    ram.ram_di            = wr_data;
    ram.ram_pwrbus_ram_pd = 32'd0;

    // The macro reads old contents at the capture edge, so a same-edge write is forwarded.
    // Out-of-range reads win over forwarding and return zero.
    ram.ram_byp_sel = 1'b0;
    ram.ram_dbyp    = '0;
    if (a_vld && adv_a) begin
      if (a_err) begin
        ram.ram_byp_sel = 1'b1;
        ram.ram_dbyp    = '0;
      end else if (collide) begin
        ram.ram_byp_sel = 1'b1;
        ram.ram_dbyp    = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_vld   <= 1'b0;
      b_vld   <= 1'b0;
      rr_last <= 1'b1;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_vld && !wr_ok;

      if (issue) begin
        a_vld   <= 1'b1;
        rr_last <= gnt1;
      end else if (adv_a) begin
        a_vld <= 1'b0;
      end

      if (a_vld && adv_a) begin
        b_vld <= 1'b1;
      end else if (rsp_rdy) begin
        b_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      a_addr <= gnt_addr;
      a_id   <= gnt1;
      a_err  <= !(gnt_addr < LIMIT);
    end
    if (a_vld && adv_a) begin
      b_id  <= a_id;
      b_err <= a_err;
    end
  end

  assign rsp_vld  = b_vld;
  assign rsp_id   = b_id;
  assign rsp_err  = b_err;
  assign rsp_data = ram.ram_dout;
  assign busy     = a_vld || b_vld;

endmodule

// File: tb/tb_sa_ram_80x17_rd_arb.sv
// tb/tb_sa_ram_80x17_rd_arb.sv - directed bench for sa_ram_80x17_rd_arb with a behavioural RAM macro
module tb_sa_ram_80x17_rd_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req_vld, r1_req_vld;
  logic        r0_req_rdy, r1_req_rdy;
  logic [6:0]  r0_req_addr, r1_req_addr;
  logic        wr_vld;
  logic [6:0]  wr_addr;
  logic [16:0] wr_data;
  logic        rsp_vld, rsp_rdy, rsp_id, rsp_err, wr_err, busy;
  logic [16:0] rsp_data;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  sa_ram_80x17_rd_arb_if #(.AW(7), .DW(17)) bus ();

  sa_ram_80x17_rd_arb #(.DEPTH(80), .AW(7), .DW(17)) dut (
    .clk(clk), .reset(reset),
    .r0_req_vld(r0_req_vld), .r0_req_rdy(r0_req_rdy), .r0_req_addr(r0_req_addr),
    .r1_req_vld(r1_req_vld), .r1_req_rdy(r1_req_rdy), .r1_req_addr(r1_req_addr),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .wr_err(wr_err), .busy(busy),
    .ram(bus)
  );

  // Macro model: latched read address, read-before-write array, registered output with bypass.
  logic [16:0] mem [0:127];
  logic [6:0]  ra_d = '0;
  logic [16:0] dout_r = '0;
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re) ra_d <= bus.ram_ra;
    if (bus.ram_ore) dout_r <= bus.ram_byp_sel ? bus.ram_dbyp : mem[ra_d];
  end
  assign bus.ram_dout = dout_r;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #4;
  endtask

  task automatic idle_inputs;
    r0_req_vld = 0; r0_req_addr = '0;
    r1_req_vld = 0; r1_req_addr = '0;
    wr_vld = 0; wr_addr = '0; wr_data = '0;
    rsp_rdy = 1;
  endtask

  task automatic write_word(input logic [6:0] a, input logic [16:0] d);
    wr_vld = 1; wr_addr = a; wr_data = d;
    tick;
    wr_vld = 0;
  endtask

  task automatic do_reset;
    idle_inputs;
    reset = 1;
    tick;
    tick;
    reset = 0;
  endtask

  task automatic test_reset;
    idle_inputs;
    reset = 1;
    tick;
    tick;
    mid;
    nvec++; if (rsp_vld !== 1'b0) begin nmis++; $display("FAIL reset_rsp_vld got %b want 0", rsp_vld); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (wr_err !== 1'b0) begin nmis++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
    nvec++; if (r0_req_rdy !== 1'b0) begin nmis++; $display("FAIL reset_r0_rdy got %b want 0", r0_req_rdy); end
    reset = 0;
    tick;
  endtask

  task automatic test_single_read;
    wr_vld = 1; wr_addr = 7'd5; wr_data = 17'h1ABCD;
    mid;
    nvec++; if ({bus.ram_we, bus.ram_wa, bus.ram_di} !== {1'b1, 7'd5, 17'h1ABCD}) begin
      nmis++; $display("FAIL wr_pass got we=%b wa=%0d di=%h want 1/5/1abcd", bus.ram_we, bus.ram_wa, bus.ram_di); end
    tick;
    wr_vld = 0;
    r0_req_vld = 1; r0_req_addr = 7'd5; rsp_rdy = 1;
    mid;
    nvec++; if ({r0_req_rdy, r1_req_rdy} !== 2'b10) begin nmis++; $display("FAIL single_rdy got %b want 10", {r0_req_rdy, r1_req_rdy}); end
    nvec++; if ({bus.ram_re, bus.ram_ra} !== {1'b1, 7'd5}) begin nmis++; $display("FAIL single_re got re=%b ra=%0d want 1/5", bus.ram_re, bus.ram_ra); end
    tick;
    r0_req_vld = 0;
    mid;
    nvec++; if ({rsp_vld, busy, bus.ram_ore} !== 3'b011) begin nmis++; $display("FAIL single_t1 got vld/busy/ore=%b want 011", {rsp_vld, busy, bus.ram_ore}); end
    tick;
    mid;
    nvec++; if ({rsp_vld, rsp_id, rsp_err} !== 3'b100) begin nmis++; $display("FAIL single_rsp_tag got %b want 100", {rsp_vld, rsp_id, rsp_err}); end
    nvec++; if (rsp_data !== 17'h1ABCD) begin nmis++; $display("FAIL single_rsp_data got %h want 1abcd", rsp_data); end
    tick;
    mid;
    nvec++; if ({rsp_vld, busy} !== 2'b00) begin nmis++; $display("FAIL single_drain got %b want 00", {rsp_vld, busy}); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [1:0]  exp_g;
    logic [16:0] exp_d;
    write_word(7'd1, 17'h00111);
    write_word(7'd2, 17'h00222);
    do_reset;
    for (int k = 0; k < 8; k++) begin
      r0_req_vld = (k < 6); r0_req_addr = 7'd1;
      r1_req_vld = (k < 6); r1_req_addr = 7'd2;
      rsp_rdy = 1;
      mid;
      if (k < 6) begin
        exp_g = (k % 2 == 1) ? 2'b01 : 2'b10;
        nvec++; if ({r0_req_rdy, r1_req_rdy} !== exp_g) begin
          nmis++; $display("FAIL rr_grant k=%0d got %b want %b", k, {r0_req_rdy, r1_req_rdy}, exp_g); end
      end
      if (k >= 2) begin
        exp_d = (k % 2 == 1) ? 17'h00222 : 17'h00111;
        nvec++; if ({rsp_vld, rsp_id} !== {1'b1, 1'(k % 2)}) begin
          nmis++; $display("FAIL rr_rsp_id k=%0d got vld=%b id=%b want 1/%0d", k, rsp_vld, rsp_id, k % 2); end
        nvec++; if (rsp_data !== exp_d) begin
          nmis++; $display("FAIL rr_rsp_data k=%0d got %h want %h", k, rsp_data, exp_d); end
      end
      tick;
    end
    idle_inputs;
    mid;
    nvec++; if (rsp_vld !== 1'b0) begin nmis++; $display("FAIL rr_extra_rsp got %b want 0", rsp_vld); end
    tick;
  endtask

  task automatic test_backpressure;
    logic [6:0]  addrs [3];
    logic [16:0] exp_d;
    addrs[0] = 7'd3; addrs[1] = 7'd4; addrs[2] = 7'd6;
    write_word(7'd3, 17'h00333);
    write_word(7'd4, 17'h00444);
    write_word(7'd6, 17'h00666);
    for (int c = 0; c < 10; c++) begin
      rsp_rdy = (c >= 6);
      r0_req_vld = (c <= 6);
      r0_req_addr = (c <= 1) ? addrs[c] : addrs[2];
      mid;
      if (c <= 6) begin
        nvec++; if (r0_req_rdy !== ((c <= 1) || (c == 6))) begin
          nmis++; $display("FAIL bp_rdy c=%0d got %b want %b", c, r0_req_rdy, ((c <= 1) || (c == 6))); end
      end
      if (c >= 2 && c <= 5) begin
        nvec++; if ({rsp_vld, rsp_data, bus.ram_ore, bus.ram_re, busy} !== {1'b1, 17'h00333, 1'b0, 1'b0, 1'b1}) begin
          nmis++; $display("FAIL bp_hold c=%0d got vld=%b data=%h ore=%b re=%b busy=%b want 1/00333/0/0/1",
                           c, rsp_vld, rsp_data, bus.ram_ore, bus.ram_re, busy); end
      end
      if (c >= 6 && c <= 8) begin
        exp_d = (c == 6) ? 17'h00333 : (c == 7) ? 17'h00444 : 17'h00666;
        nvec++; if ({rsp_vld, rsp_id, rsp_data} !== {1'b1, 1'b0, exp_d}) begin
          nmis++; $display("FAIL bp_drain c=%0d got vld=%b id=%b data=%h want 1/0/%h", c, rsp_vld, rsp_id, rsp_data, exp_d); end
      end
      if (c == 9) begin
        nvec++; if ({rsp_vld, busy} !== 2'b00) begin nmis++; $display("FAIL bp_empty got %b want 00", {rsp_vld, busy}); end
      end
      tick;
    end
    idle_inputs;
  endtask

  task automatic test_collision;
    write_word(7'd9, 17'h00001);
    write_word(7'd10, 17'h0AAAA);
    r1_req_vld = 1; r1_req_addr = 7'd9;
    mid;
    nvec++; if (r1_req_rdy !== 1'b1) begin nmis++; $display("FAIL col_rdy got %b want 1", r1_req_rdy); end
    tick;
    r1_req_vld = 0;
    wr_vld = 1; wr_addr = 7'd9; wr_data = 17'h15555;
    mid;
    nvec++; if ({bus.ram_ore, bus.ram_byp_sel, bus.ram_dbyp} !== {1'b1, 1'b1, 17'h15555}) begin
      nmis++; $display("FAIL col_bypass got ore=%b sel=%b dbyp=%h want 1/1/15555", bus.ram_ore, bus.ram_byp_sel, bus.ram_dbyp); end
    tick;
    wr_vld = 0;
    mid;
    nvec++; if ({rsp_vld, rsp_id, rsp_err, rsp_data} !== {3'b110, 17'h15555}) begin
      nmis++; $display("FAIL col_rsp got vld/id/err=%b data=%h want 110/15555", {rsp_vld, rsp_id, rsp_err}, rsp_data); end
    tick;
    r1_req_vld = 1; r1_req_addr = 7'd9;
    tick;
    r1_req_vld = 0;
    wr_vld = 1; wr_addr = 7'd10; wr_data = 17'h0BBBB;
    mid;
    nvec++; if ({bus.ram_ore, bus.ram_byp_sel, bus.ram_dbyp} !== {1'b1, 1'b0, 17'h0}) begin
      nmis++; $display("FAIL col_nobypass got ore=%b sel=%b dbyp=%h want 1/0/0", bus.ram_ore, bus.ram_byp_sel, bus.ram_dbyp); end
    tick;
    wr_vld = 0;
    r1_req_vld = 1; r1_req_addr = 7'd10;
    mid;
    nvec++; if ({rsp_vld, rsp_data} !== {1'b1, 17'h15555}) begin
      nmis++; $display("FAIL col_rsp2 got vld=%b data=%h want 1/15555", rsp_vld, rsp_data); end
    tick;
    r1_req_vld = 0;
    tick;
    mid;
    nvec++; if ({rsp_vld, rsp_id, rsp_data} !== {2'b11, 17'h0BBBB}) begin
      nmis++; $display("FAIL col_rsp3 got vld=%b id=%b data=%h want 1/1/0bbbb", rsp_vld, rsp_id, rsp_data); end
    tick;
    idle_inputs;
  endtask

  task automatic test_out_of_range;
    r0_req_vld = 1; r0_req_addr = 7'd80;
    wr_vld = 1; wr_addr = 7'd95; wr_data = 17'h1FFFF;
    mid;
    nvec++; if ({r0_req_rdy, bus.ram_we, wr_err} !== 3'b100) begin
      nmis++; $display("FAIL oor_issue got rdy/we/wr_err=%b want 100", {r0_req_rdy, bus.ram_we, wr_err}); end
    tick;
    r0_req_vld = 0; wr_vld = 0;
    mid;
    nvec++; if ({wr_err, bus.ram_ore, bus.ram_byp_sel, bus.ram_dbyp} !== {3'b111, 17'h0}) begin
      nmis++; $display("FAIL oor_capture got wr_err/ore/sel=%b dbyp=%h want 111/0", {wr_err, bus.ram_ore, bus.ram_byp_sel}, bus.ram_dbyp); end
    tick;
    mid;
    nvec++; if ({wr_err, rsp_vld, rsp_id, rsp_err, rsp_data} !== {4'b0101, 17'h0}) begin
      nmis++; $display("FAIL oor_rsp got wr_err/vld/id/err=%b data=%h want 0101/0", {wr_err, rsp_vld, rsp_id, rsp_err}, rsp_data); end
    tick;
  endtask

  task automatic test_reset_midflight;
    r0_req_vld = 1; r0_req_addr = 7'd1;
    tick;
    r0_req_addr = 7'd2;
    tick;
    r0_req_vld = 0;
    reset = 1;
    mid;
    nvec++; if ({rsp_vld, busy} !== 2'b11) begin nmis++; $display("FAIL rst_pre got %b want 11", {rsp_vld, busy}); end
    tick;
    reset = 0;
    r0_req_vld = 1; r0_req_addr = 7'd1;
    r1_req_vld = 1; r1_req_addr = 7'd2;
    mid;
    nvec++; if ({rsp_vld, busy} !== 2'b00) begin nmis++; $display("FAIL rst_flush got %b want 00", {rsp_vld, busy}); end
    nvec++; if ({r0_req_rdy, r1_req_rdy} !== 2'b10) begin nmis++; $display("FAIL rst_first_tie got %b want 10", {r0_req_rdy, r1_req_rdy}); end
    tick;
    idle_inputs;
    tick;
    mid;
    nvec++; if ({rsp_vld, rsp_id, rsp_data} !== {2'b10, 17'h00111}) begin
      nmis++; $display("FAIL rst_after got vld=%b id=%b data=%h want 1/0/00111", rsp_vld, rsp_id, rsp_data); end
    tick;
    tick;
  endtask

  initial begin
    idle_inputs;
    reset = 1;
    test_reset;
    test_single_read;
    test_round_robin;
    test_backpressure;
    test_collision;
    test_out_of_range;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
